// File: rtl/ex_mem_reg_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// The control bundle groups the four MEM/WB control bits so they move together.
package ex_mem_reg_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_REG_DEF  = 5;

  localparam logic [NB_REG_DEF-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  // What the register does on the coming edge, after all gating is resolved.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2
  } action_e;

endpackage

// File: rtl/ex_mem_reg_sat_counter.sv
// Saturating up-counter used for the debug unit's instruction/bubble statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inc,
  output logic [NB_CNT-1:0] o_count
);

  logic [NB_CNT-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU result, store data, destination and MEM/WB control,
// with debug run/step gating, stall, flush bubble, sticky halt and saturating statistics.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_store_data,
  input  logic [NB_REG-1:0]  i_write_reg,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_mem_to_reg,
  input  logic               i_halt,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_DATA-1:0] o_store_data,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg,
  output logic               o_valid,
  output logic               o_halt,
  output logic [NB_CNT-1:0]  o_instr_count,
  output logic [NB_CNT-1:0]  o_bubble_count
);

  action_e            action;
  logic [NB_DATA-1:0] alu_q, alu_d;
  logic [NB_DATA-1:0] store_q, store_d;
  logic [NB_REG-1:0]  write_reg_q, write_reg_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic               halt_q, halt_d;

  // Priority: frozen by debug or halt, then flush, then stall, then load/bubble by i_valid.
  always_comb begin
    action = ACT_HOLD;
    if (!i_enable || halt_q) begin
      action = ACT_HOLD;
    end else if (i_flush) begin
      action = ACT_BUBBLE;
    end else if (i_stall) begin
      action = ACT_HOLD;
    end else if (i_valid) begin
      action = ACT_LOAD;
    end else begin
      action = ACT_BUBBLE;
    end
  end

  // NOTE: every next-state signal gets a default first, so no path through the case infers a latch.
  always_comb begin
    alu_d       = alu_q;
    store_d     = store_q;
    write_reg_d = write_reg_q;
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    halt_d      = halt_q;
    case (action)
      ACT_BUBBLE: begin
        alu_d       = '0;
        store_d     = '0;
        write_reg_d = '0;
        ctrl_d      = '0;
        valid_d     = 1'b0;
      end
      ACT_LOAD: begin
        alu_d       = i_alu_result;
        store_d     = i_store_data;
        write_reg_d = i_write_reg;
        // Writes to $zero are dropped here so WB never has to check the address.
        ctrl_d      = '{reg_write:  i_reg_write && (i_write_reg != NB_REG'(ZERO_REG)),
                        mem_read:   i_mem_read,
                        mem_write:  i_mem_write,
                        mem_to_reg: i_mem_to_reg};
        valid_d     = 1'b1;
        halt_d      = i_halt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_q       <= '0;
      store_q     <= '0;
      write_reg_q <= '0;
      ctrl_q      <= '0;
      valid_q     <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      alu_q       <= alu_d;
      store_q     <= store_d;
      write_reg_q <= write_reg_d;
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      halt_q      <= halt_d;
    end
  end

  sat_counter #(.NB_CNT(NB_CNT)) u_instr_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (action == ACT_LOAD),
    .o_count (o_instr_count)
  );

  sat_counter #(.NB_CNT(NB_CNT)) u_bubble_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (action == ACT_BUBBLE),
    .o_count (o_bubble_count)
  );

  assign o_alu_result = alu_q;
  assign o_store_data = store_q;
  assign o_write_reg  = write_reg_q;
  assign o_reg_write  = ctrl_q.reg_write;
  assign o_mem_read   = ctrl_q.mem_read;
  assign o_mem_write  = ctrl_q.mem_write;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_valid      = valid_q;
  assign o_halt       = halt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: a 32-bit-counter instance and a 3-bit-counter instance
// share stimulus; a behavioural model pushes expected state, a monitor pops and compares.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, stall, flush, valid, halt;
  logic [31:0] alu, sdata;
  logic [4:0]  wr;
  logic        rw, mr, mw, m2r;

  logic [31:0] o_alu, o_sd, o3_alu, o3_sd;
  logic [4:0]  o_wr, o3_wr;
  logic        o_rw, o_mr, o_mw, o_m2r, o_valid, o_halt;
  logic        o3_rw, o3_mr, o3_mw, o3_m2r, o3_valid, o3_halt;
  logic [31:0] o_ic, o_bc;
  logic [2:0]  o3_ic, o3_bc;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_alu_result(alu), .i_store_data(sdata), .i_write_reg(wr),
    .i_reg_write(rw), .i_mem_read(mr), .i_mem_write(mw), .i_mem_to_reg(m2r), .i_halt(halt),
    .o_alu_result(o_alu), .o_store_data(o_sd), .o_write_reg(o_wr), .o_reg_write(o_rw),
    .o_mem_read(o_mr), .o_mem_write(o_mw), .o_mem_to_reg(o_m2r), .o_valid(o_valid),
    .o_halt(o_halt), .o_instr_count(o_ic), .o_bubble_count(o_bc)
  );

  ex_mem_reg #(.NB_CNT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_stall(stall), .i_flush(flush),
    .i_valid(valid), .i_alu_result(alu), .i_store_data(sdata), .i_write_reg(wr),
    .i_reg_write(rw), .i_mem_read(mr), .i_mem_write(mw), .i_mem_to_reg(m2r), .i_halt(halt),
    .o_alu_result(o3_alu), .o_store_data(o3_sd), .o_write_reg(o3_wr), .o_reg_write(o3_rw),
    .o_mem_read(o3_mr), .o_mem_write(o3_mw), .o_mem_to_reg(o3_m2r), .o_valid(o3_valid),
    .o_halt(o3_halt), .o_instr_count(o3_ic), .o_bubble_count(o3_bc)
  );

  typedef struct {
    logic [31:0] alu, sd;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r, valid, halt;
    int unsigned ic, bc, ic3, bc3;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned c, input int unsigned mx);
    return (c >= mx) ? mx : c + 1;
  endfunction

  task automatic model_reset();
    m = '{alu: 0, sd: 0, wr: 0, rw: 0, mr: 0, mw: 0, m2r: 0, valid: 0, halt: 0,
          ic: 0, bc: 0, ic3: 0, bc3: 0};
  endtask

  // Behaviour of one rising edge, written directly from the block's rules.
  task automatic model_edge();
    if (!en || m.halt) return;
    if (flush || (!stall && !valid)) begin
      m.alu = 0; m.sd = 0; m.wr = 0;
      m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.valid = 0;
      m.bc  = sat_inc(m.bc, 32'hFFFF_FFFF);
      m.bc3 = sat_inc(m.bc3, 7);
    end else if (!stall) begin
      m.alu = alu; m.sd = sdata; m.wr = wr;
      m.rw = rw && (wr != 0); m.mr = mr; m.mw = mw; m.m2r = m2r;
      m.valid = 1; m.halt = halt;
      m.ic  = sat_inc(m.ic, 32'hFFFF_FFFF);
      m.ic3 = sat_inc(m.ic3, 7);
    end
  endtask

  // Drive one cycle of inputs mid-low-phase and queue the state expected after the edge.
  task automatic apply(input logic r, input logic e, input logic s, input logic f,
                       input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] w, input logic [3:0] c, input logic h);
    @(negedge clk);
    #1;
    rst_n = r; en = e; stall = s; flush = f; valid = v;
    alu = a; sdata = d; wr = w; {rw, mr, mw, m2r} = c; halt = h;
    if (!r) model_reset();
    else model_edge();
    sb.push_back(m);
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] w, input logic [3:0] c,
                      input logic h);
    apply(1, 1, 0, 0, 1, a, ~a, w, c, h);
  endtask

  // Reset asserted while outputs are loaded must clear them before any further edge.
  task automatic async_reset_check();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_alu",   o_alu,   0);
    check("async_rst_wr",    o_wr,    0);
    check("async_rst_rw",    o_rw,    0);
    check("async_rst_valid", o_valid, 0);
    check("async_rst_halt",  o_halt,  0);
    check("async_rst_ic",    o_ic,    0);
    check("async_rst_bc",    o_bc,    0);
    model_reset();
    sb.push_back(m);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("alu_result",   o_alu,   e.alu);
        check("store_data",   o_sd,    e.sd);
        check("write_reg",    o_wr,    e.wr);
        check("reg_write",    o_rw,    e.rw);
        check("mem_read",     o_mr,    e.mr);
        check("mem_write",    o_mw,    e.mw);
        check("mem_to_reg",   o_m2r,   e.m2r);
        check("valid",        o_valid, e.valid);
        check("halt",         o_halt,  e.halt);
        check("instr_count",  o_ic,    e.ic);
        check("bubble_count", o_bc,    e.bc);
        check("instr_cnt3",   o_ic3_ext(), e.ic3);
        check("bubble_cnt3",  o_bc3_ext(), e.bc3);
      end
    end
  end

  function automatic logic [31:0] o_ic3_ext();
    return {29'd0, o3_ic};
  endfunction

  function automatic logic [31:0] o_bc3_ext();
    return {29'd0, o3_bc};
  endfunction

  initial begin : stimulus
    rst_n = 0; en = 0; stall = 0; flush = 0; valid = 0; halt = 0;
    alu = 0; sdata = 0; wr = 0; {rw, mr, mw, m2r} = 4'b0;
    model_reset();
    repeat (2) apply(0, 0, 0, 0, 0, 0, 0, 0, 4'b0, 0);

    // Basic load, then stall 3 cycles with changing inputs, then flush+stall.
    load(32'h0000_0010, 5'd5, 4'b1000, 0);
    repeat (3) apply(1, 1, 1, 0, 1, $urandom, $urandom, 5'd9, 4'b1111, 0);
    apply(1, 1, 1, 1, 1, 32'h1234, 32'h5678, 5'd3, 4'b1010, 0);

    // Write to $zero, then a store, then a load-use style bundle.
    load(32'hDEAD_BEEF, 5'd0, 4'b1001, 0);
    load(32'h0000_0100, 5'd7, 4'b0010, 0);
    load(32'h0000_0200, 5'd31, 4'b1101, 0);

    // Debug gating: 4 frozen cycles, one enable pulse, frozen again.
    repeat (4) apply(1, 0, 0, 0, 1, $urandom, $urandom, 5'd12, 4'b1000, 0);
    apply(1, 1, 0, 0, 1, 32'hCAFE_0001, 32'h0, 5'd12, 4'b1000, 0);
    repeat (2) apply(1, 0, 0, 0, 1, $urandom, $urandom, 5'd13, 4'b1000, 1);

    // Bubble via i_valid=0, then halt: later valid inputs and flushes are ignored.
    apply(1, 1, 0, 0, 0, 32'h55, 32'h66, 5'd4, 4'b1000, 0);
    load(32'h0000_0FFF, 5'd2, 4'b1010, 1);
    repeat (3) load($urandom, 5'd8, 4'b1000, 0);
    apply(1, 1, 0, 1, 0, 0, 0, 0, 4'b0, 0);

    // Reset mid-halt clears everything immediately.
    async_reset_check();
    apply(1, 1, 0, 0, 1, 32'h77, 32'h88, 5'd6, 4'b1000, 0);

    // Saturation: the 3-bit counters stop at 7.
    async_reset_check();
    repeat (10) load($urandom, 5'd1, 4'b1000, 0);
    repeat (9) apply(1, 1, 0, 1, 0, 0, 0, 0, 4'b0, 0);

    // Randomized traffic; a halted pipeline is occasionally recovered by reset.
    for (int i = 0; i < 300; i++) begin
      logic r;
      r = !(m.halt && ($urandom_range(0, 3) == 0)) && ($urandom_range(0, 99) != 0);
      apply(r, $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0,
            $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            4'($urandom), $urandom_range(0, 24) == 0);
    end
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries left unchecked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the MIPS-DLX datapath, directly downstream of the EX-stage RegDst mux2 (5-bit destination select) and the ALU.
- Captures ALU result, store data, selected destination register and MEM/WB control.
- Supports debug-unit run/step gating, hazard stall, flush bubble and sticky halt.
- Keeps saturating retired-instruction and bubble counters for the debug unit.

Parameters:
- NB_DATA, 32, width of ALU result and store data
- NB_REG, 5, width of register address (matches mux2 N_BITS in EX)
- NB_CNT, 32, width of each statistics counter

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  debug-unit run/step enable; 0 freezes the whole block
- i_stall  in  1  hold current contents
- i_flush  in  1  load a bubble
- i_valid  in  1  EX stage holds a real instruction
- i_alu_result  in  NB_DATA  ALU output
- i_store_data  in  NB_DATA  forwarded rt value for SW
- i_write_reg  in  NB_REG  destination from RegDst mux2 output
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg  in  1 each  control bits
- i_halt  in  1  EX instruction is HALT
- o_alu_result, o_store_data  out  NB_DATA  registered
- o_write_reg  out  NB_REG  registered
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  out  1 each  registered control
- o_valid  out  1  stage holds a real instruction
- o_halt  out  1  sticky halt reached MEM
- o_instr_count  out  NB_CNT  valid instructions loaded
- o_bubble_count  out  NB_CNT  bubbles loaded

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, counters 0, halt cleared; release takes effect at next rising edge.
- Latency: 1 cycle, input to output. No combinational input-to-output path.
- Per-edge priority: reset > !i_enable > o_halt > i_flush > i_stall > load.
- !i_enable: every register holds, counters included.
- o_halt=1: every register holds, counters included, until reset.
- i_flush=1: data/reg fields 0, control 0, o_valid 0, bubble_count +1. Flush beats stall when both are asserted.
- i_stall=1 (no flush): every register holds; counters unchanged.
- Load with i_valid=1: capture all fields; instr_count +1. If i_halt=1, o_halt is set on the same edge.
- Load with i_valid=0: as flush; bubble_count +1.
- Write to $zero: if i_write_reg==0, o_reg_write is forced 0 on capture. Other fields are captured normally.
- A halt instruction captured with reg_write/mem_write is stored as given; downstream gates on o_valid.
- Counters saturate at all-ones; no wrap.
- Reset mid-stall or mid-halt returns all state to reset values immediately.

Decomposition:
- Shared package: NB_DATA/NB_REG defaults; control-bundle typedef (reg_write, mem_read, mem_write, mem_to_reg); zero-register constant.
- One sub-module: sat_counter (NB_CNT, enable, async active-low reset), instantiated twice.

Test Plan:
- Reset check: assert i_rst_n=0 mid-cycle with outputs loaded -> all outputs 0 immediately, before next edge.
- Load: i_enable=1, i_valid=1, alu=0x0000_0010, write_reg=5, reg_write=1 -> next cycle o_alu_result=0x10, o_write_reg=5, o_reg_write=1, o_valid=1, instr_count=1.
- Stall/flush: stall 3 cycles -> outputs and counters frozen. Then flush+stall -> bubble with o_valid=0 and bubble_count=1.
- $zero write: write_reg=0, reg_write=1 -> o_reg_write=0, o_write_reg=0, instr_count increments.
- Debug gating: i_enable=0 with new inputs for 4 cycles -> no change. Single-cycle enable pulse -> exactly one load.
- Halt: load i_halt=1 -> o_halt=1 next cycle. Further valid inputs are ignored and counters stop. Reset clears o_halt.
- Saturation: NB_CNT=3, issue 10 valid loads -> o_instr_count stays at 7.
